anita3_scaler_readout: RTL and testbench

ANITA3_SCALER_READOUT -- requirements
Module: anita3_scaler_readout

---
 rtl/anita3_scaler_readout.sv | 160 ++++++++++++++++
 tb/tb_anita3_scaler_readout.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/anita3_scaler_readout.sv
// Once-per-second scaler snapshot streamed as a header word plus NUM_CH data words.
// Optional macro ANITA3_SCALER_READOUT_CHECKSUM_EN appends an XOR checksum word to each frame.
module anita3_scaler_readout #(
  parameter int NUM_CH = 16,
  parameter int WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    pps_i,
  input  logic [NUM_CH*WIDTH-1:0] scalers_i,
  output logic [15:0]             dat_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    overrun_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
`ifdef ANITA3_SCALER_READOUT_CHECKSUM_EN
  localparam bit DATA_ENDS_FRAME = 1'b0;
`else
  localparam bit DATA_ENDS_FRAME = 1'b1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    HEADER,
`ifdef ANITA3_SCALER_READOUT_CHECKSUM_EN
    DATA,
    CHECK
`else
    DATA
`endif
  } state_t;

  state_t           state;
  logic [14:0]      sec;
  logic [14:0]      hdr_sec;
  logic             ovf;
  logic [IDX_W-1:0] ch_idx;
  logic [IDX_W-1:0] next_idx;
  logic [WIDTH-1:0] snapshot [NUM_CH];
  logic             xfer;
  logic             frame_done;
  logic             accept;
  logic             drop;

  assign xfer       = valid_o & ready_i;
  assign frame_done = xfer & last_o;
  assign accept     = pps_i & ((state == IDLE) | frame_done);
  assign drop       = pps_i & ~accept;
  assign next_idx   = ch_idx + 1'b1;

  // Upstream scalers latch on the PPS edge, so their outputs settle during CAPTURE.
  always_ff @(posedge clk_i) begin
    if (state == CAPTURE) begin
      for (int k = 0; k < NUM_CH; k++) begin
        snapshot[k] <= scalers_i[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef ANITA3_SCALER_READOUT_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      csum <= '0;
    end else if (state == CAPTURE) begin
      csum <= '0;
    end else if (xfer) begin
      csum <= csum ^ dat_o;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      sec       <= '0;
      hdr_sec   <= '0;
      ovf       <= 1'b0;
      ch_idx    <= '0;
      dat_o     <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= drop;
      if (pps_i) sec <= sec + 15'd1;
      if (accept) hdr_sec <= sec + 15'd1;
      // A drop in the same cycle as the header transfer must survive into the next header.
      if (drop) ovf <= 1'b1;
      else if (xfer && state == HEADER) ovf <= 1'b0;

      if (frame_done) begin
        ch_idx  <= '0;
        dat_o   <= '0;
        valid_o <= 1'b0;
        last_o  <= 1'b0;
        if (accept) begin
          state  <= CAPTURE;
          busy_o <= 1'b1;
        end else begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state  <= CAPTURE;
              busy_o <= 1'b1;
            end
          end
          CAPTURE: begin
            state   <= HEADER;
            ch_idx  <= '0;
            valid_o <= 1'b1;
            last_o  <= 1'b0;
            dat_o   <= {ovf | drop, hdr_sec};
          end
          HEADER: begin
            if (xfer) begin
              state  <= DATA;
              dat_o  <= 16'(snapshot[0]);
              last_o <= DATA_ENDS_FRAME && (NUM_CH == 1);
            end
          end
          DATA: begin
            if (xfer) begin
`ifdef ANITA3_SCALER_READOUT_CHECKSUM_EN
              if (ch_idx == LAST_IDX) begin
                state  <= CHECK;
                dat_o  <= csum ^ dat_o;
                last_o <= 1'b1;
              end else
`endif
              begin
                ch_idx <= next_idx;
                dat_o  <= 16'(snapshot[next_idx]);
                last_o <= DATA_ENDS_FRAME && (next_idx == LAST_IDX);
              end
            end
          end
`ifdef ANITA3_SCALER_READOUT_CHECKSUM_EN
          CHECK: begin
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anita3_scaler_readout.sv
// Self-checking bench for anita3_scaler_readout: directed frames plus random PPS/backpressure
// checked every cycle against a frame-queue reference model.
module tb_anita3_scaler_readout;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam logic [NCH*W-1:0] SCL = {8'hFF, 8'h33, 8'h22, 8'h11};

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b1;
  logic             pps_i = 1'b0;
  logic             ready_i = 1'b0;
  logic [NCH*W-1:0] scalers_i = '0;
  logic [15:0]      dat_o;
  logic             valid_o, last_o, busy_o, overrun_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  anita3_scaler_readout #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .pps_i     (pps_i),
    .scalers_i (scalers_i),
    .dat_o     (dat_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .last_o    (last_o),
    .busy_o    (busy_o),
    .overrun_o (overrun_o)
  );

  // Reference model: queue of words still owed for the current frame.
  logic [15:0] exp_q[$];
  bit          hdr_front;
  bit          cap_pend;
  logic [14:0] m_sec, m_hsec;
  bit          m_flag, m_ovr;

  logic [15:0] got_q[$];
  bit          got_last_q[$];
  logic        obs_valid, obs_overrun;
  logic [15:0] obs_dat;

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    hdr_front = 0;
    cap_pend  = 0;
    m_sec     = '0;
    m_hsec    = '0;
    m_flag    = 0;
    m_ovr     = 0;
  endtask

  task automatic modelStep(input logic pps, input logic rdy, input logic [NCH*W-1:0] scl);
    bit mv, xfer, fin, busy, acc, drp, hdr_x;
    logic [15:0] cs;
    mv    = exp_q.size() > 0;
    xfer  = mv && rdy;
    fin   = xfer && exp_q.size() == 1;
    busy  = cap_pend || mv;
    acc   = pps && (!busy || fin);
    drp   = pps && !acc;
    hdr_x = xfer && hdr_front;
    if (xfer) begin
      void'(exp_q.pop_front());
      hdr_front = 0;
    end
    if (cap_pend) begin
      exp_q.push_back({m_flag | drp, m_hsec});
      cs = {m_flag | drp, m_hsec};
      for (int k = 0; k < NCH; k++) begin
        exp_q.push_back(16'(scl[k*W +: W]));
        cs = cs ^ 16'(scl[k*W +: W]);
      end
`ifdef ANITA3_SCALER_READOUT_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
      hdr_front = 1;
      cap_pend  = 0;
    end
    if (drp) m_flag = 1;
    else if (hdr_x) m_flag = 0;
    if (pps) m_sec = m_sec + 15'd1;
    if (acc) begin
      cap_pend = 1;
      m_hsec   = m_sec;
    end
    m_ovr = drp;
  endtask

  task automatic checkOutput();
    logic mv;
    mv = exp_q.size() > 0;
    checkVal("valid", 16'(valid_o), 16'(mv));
    if (mv) begin
      checkVal("dat", dat_o, exp_q[0]);
      checkVal("last", 16'(last_o), 16'(exp_q.size() == 1));
    end else begin
      checkVal("last_idle", 16'(last_o), 16'h0);
    end
    checkVal("busy", 16'(busy_o), 16'(cap_pend || mv));
    checkVal("overrun", 16'(overrun_o), 16'(m_ovr));
  endtask

  task automatic applyStimulus(input logic pps, input logic rdy, input logic [NCH*W-1:0] scl);
    @(negedge clk_i);
    checkOutput();
    obs_valid   = valid_o;
    obs_dat     = dat_o;
    obs_overrun = overrun_o;
    if (valid_o && rdy) begin
      got_q.push_back(dat_o);
      got_last_q.push_back(last_o);
    end
    pps_i     = pps;
    ready_i   = rdy;
    scalers_i = scl;
    modelStep(pps, rdy, scl);
  endtask

  task automatic doReset();
    #2;
    rst_n_i = 1'b0;
    pps_i   = 1'b0;
    ready_i = 1'b0;
    #1;
    checkVal("rst_dat", dat_o, 16'h0);
    checkVal("rst_valid", 16'(valid_o), 16'h0);
    checkVal("rst_last", 16'(last_o), 16'h0);
    checkVal("rst_busy", 16'(busy_o), 16'h0);
    checkVal("rst_overrun", 16'(overrun_o), 16'h0);
    modelReset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic checkFrame(input string tag);
    logic [15:0] e[$];
    e = '{16'h0001, 16'h0011, 16'h0022, 16'h0033, 16'h00FF};
`ifdef ANITA3_SCALER_READOUT_CHECKSUM_EN
    e.push_back(16'h0001 ^ 16'h0011 ^ 16'h0022 ^ 16'h0033 ^ 16'h00FF);
`endif
    checkVal({tag, "_count"}, 16'(got_q.size()), 16'(e.size()));
    for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
      checkVal({tag, "_word"}, got_q[i], e[i]);
      checkVal({tag, "_lastflag"}, 16'(got_last_q[i]), 16'(i == e.size() - 1));
    end
  endtask

  initial begin
    modelReset();

    // Basic frame with ready held high, including header latency.
    doReset();
    got_q.delete(); got_last_q.delete();
    applyStimulus(1'b1, 1'b1, SCL);
    applyStimulus(1'b0, 1'b1, SCL);
    checkVal("capture_not_valid", 16'(obs_valid), 16'h0);
    applyStimulus(1'b0, 1'b1, SCL);
    checkVal("hdr_latency_valid", 16'(obs_valid), 16'h1);
    checkVal("hdr_latency_dat", obs_dat, 16'h0001);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, SCL);
    checkFrame("basic");

    // Same frame under 1,0,0,1 backpressure; scalers change after capture.
    doReset();
    got_q.delete(); got_last_q.delete();
    applyStimulus(1'b1, 1'b1, SCL);
    applyStimulus(1'b0, 1'b1, SCL);
    for (int i = 0; i < 24; i++) applyStimulus(1'b0, (i % 4 == 0) || (i % 4 == 3), $urandom);
    checkFrame("stall");

    // Dropped PPS during a stalled DATA word.
    doReset();
    applyStimulus(1'b1, 1'b1, SCL);
    applyStimulus(1'b0, 1'b1, SCL);
    applyStimulus(1'b0, 1'b1, SCL);
    applyStimulus(1'b1, 1'b0, SCL);
    applyStimulus(1'b0, 1'b0, SCL);
    checkVal("drop_pulse", 16'(obs_overrun), 16'h1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, SCL);
    applyStimulus(1'b1, 1'b1, SCL);
    applyStimulus(1'b0, 1'b1, SCL);
    applyStimulus(1'b0, 1'b0, SCL);
    checkVal("overrun_hdr", obs_dat, 16'h8003);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, SCL);

    // Seconds counter wrap: 32767 pulses reach 0x7FFF, the next one wraps to zero.
    doReset();
    for (int i = 0; i < 32767; i++) applyStimulus(1'b1, 1'b1, SCL);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, SCL);
    applyStimulus(1'b1, 1'b1, SCL);
    applyStimulus(1'b0, 1'b1, SCL);
    applyStimulus(1'b0, 1'b1, SCL);
    checkVal("wrap_valid", 16'(obs_valid), 16'h1);
    checkVal("wrap_sec", {1'b0, obs_dat[14:0]}, 16'h0000);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, SCL);

    // Reset asserted mid-DATA, then a fresh frame.
    doReset();
    applyStimulus(1'b1, 1'b1, SCL);
    applyStimulus(1'b0, 1'b1, SCL);
    applyStimulus(1'b0, 1'b1, SCL);
    applyStimulus(1'b0, 1'b1, SCL);
    applyStimulus(1'b0, 1'b0, SCL);
    doReset();
    got_q.delete(); got_last_q.delete();
    applyStimulus(1'b1, 1'b1, SCL);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, SCL);
    checkFrame("after_reset");

    // Random PPS, backpressure and scaler values.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(7) == 0, $urandom_range(3) != 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
